// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative radix-2 RV32M multiply/divide unit.
// Fixed 33-cycle latency from accept to the done pulse, for every op.
// Optional macro MDU_DIV_EN: when defined, DIV/DIVU/REM/REMU are implemented.
// When it is undefined, divide ops still take the normal timing but return 0
// and pulse illegal together with done.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_we,
  output logic            illegal
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            neg_a_q, neg_b_q;
  logic            busy_q, done_q, wb_we_q, illegal_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      wb_addr_q;

  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN-1:0] res_d;
  logic            ill_d;

  // Operand conditioning at accept: signedness per op, then magnitudes
  always_comb begin
    sgn_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    mag_a = (sgn_a && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b = (sgn_b && op_b[XLEN-1]) ? -op_b : op_b;
  end

  // One radix-2 step: shift-add multiply or restoring divide on {hi_q, lo_q}
  always_comb begin
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    r_sh    = {hi_q, lo_q[XLEN-1]};
    diff    = r_sh - {1'b0, b_q};
    ge      = ~diff[XLEN];
    hi_d    = mul_sum[XLEN:1];
    lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    if (funct3_q[2]) begin
      hi_d = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge};
    end
`endif
  end

  // Sign fix-up and result select, consumed on the FIN edge
  always_comb begin
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    prod    = {hi_q, lo_q};
    prod    = (neg_a_q ^ neg_b_q) ? -prod : prod;
    mul_res = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    // Divide by zero: magnitude division already leaves |a| as remainder,
    // but the quotient must bypass the sign fix to stay all-ones.
    quot    = (b_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
    rem     = neg_a_q ? -hi_q : hi_q;
`ifdef MDU_DIV_EN
    res_d   = funct3_q[2] ? (funct3_q[1] ? rem : quot) : mul_res;
    ill_d   = 1'b0;
`else
    res_d   = (funct3_q[2] || (quot == rem && 1'b0)) ? '0 : mul_res;
    ill_d   = funct3_q[2];
`endif
  end

  // Control FSM with registered outputs and iterative datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      funct3_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      done_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            count_q   <= '0;
            funct3_q  <= funct3;
            hi_q      <= '0;
            lo_q      <= mag_a;
            b_q       <= mag_b;
            neg_a_q   <= sgn_a & op_a[XLEN-1];
            neg_b_q   <= sgn_b & op_b[XLEN-1];
            wb_addr_q <= rd_in;
          end
        end
        S_RUN: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(ITERS - 1)) state_q <= S_FIN;
          end
        end
        S_FIN: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_DONE;
            result_q  <= res_d;
            done_q    <= 1'b1;
            wb_we_q   <= (wb_addr_q != '0) && !ill_d;
            illegal_q <= ill_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign wb_we   = wb_we_q;
  assign illegal = illegal_q;

endmodule
